forwarding_hazard_unit: RTL and testbench

- Pipeline-control block for the 5-stage MIPS core.
- Tracks destination-register and write-enable information for the EX, MEM and WB stages in internal shadow registers.
- Generates the 2-bit selectors that drive the ALU-operand 3-to-1 forwarding multiplexers, plus a load-use stall request to the PC, IF/ID and ID/EX registers.
- Keeps a saturating count of stall cycles for performance debug.

---
 rtl/forwarding_hazard_unit.sv | 111 +++++++++++
 tb/tb_forwarding_hazard_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Purpose : EX/MEM/WB destination tracking, ALU operand forwarding selectors,
//           load-use stall request and a saturating stall-cycle counter.
// Latency : ForwardA/ForwardB/Stall are combinational from shadow slots and ID
//           inputs; shadow slots and StallCount update on the rising clk edge.
// Backpressure: Stall holds PC and IF/ID and forces a bubble into the EX slot.
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   ID_*                  fields of the instruction currently in ID
//   Flush                 squash the instruction entering EX
//   ForwardA, ForwardB    00 = register file, 01 = MEM/WB, 10 = EX/MEM
//   Stall                 load-use hazard request
//   StallCount            saturating count of cycles with Stall=1
module forwarding_hazard_unit #(
  parameter int REG_ADDR_BITS = 5,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ID_Valid,
  input  logic [REG_ADDR_BITS-1:0] ID_Rs,
  input  logic [REG_ADDR_BITS-1:0] ID_Rt,
  input  logic                     ID_UsesRt,
  input  logic [REG_ADDR_BITS-1:0] ID_WriteReg,
  input  logic                     ID_RegWrite,
  input  logic                     ID_MemRead,
  input  logic                     Flush,
  output logic [1:0]               ForwardA,
  output logic [1:0]               ForwardB,
  output logic                     Stall,
  output logic [COUNT_WIDTH-1:0]   StallCount
);

  localparam logic [REG_ADDR_BITS-1:0] REG_ZERO = '0;
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // EX slot
  logic [REG_ADDR_BITS-1:0] ex_rs;
  logic [REG_ADDR_BITS-1:0] ex_rt;
  logic [REG_ADDR_BITS-1:0] ex_write_reg;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  // MEM slot
  logic [REG_ADDR_BITS-1:0] mem_write_reg;
  logic                     mem_reg_write;
  // WB slot
  logic [REG_ADDR_BITS-1:0] wb_write_reg;
  logic                     wb_reg_write;

  logic mem_hits_rs, mem_hits_rt, wb_hits_rs, wb_hits_rt;
  logic load_in_ex, load_hits_id;

  // A slot can only supply a value if it writes a non-zero register.
  assign mem_hits_rs = mem_reg_write && (mem_write_reg != REG_ZERO) && (mem_write_reg == ex_rs);
  assign mem_hits_rt = mem_reg_write && (mem_write_reg != REG_ZERO) && (mem_write_reg == ex_rt);
  assign wb_hits_rs  = wb_reg_write  && (wb_write_reg  != REG_ZERO) && (wb_write_reg  == ex_rs);
  assign wb_hits_rt  = wb_reg_write  && (wb_write_reg  != REG_ZERO) && (wb_write_reg  == ex_rt);

  // MEM is checked first: it holds the younger of the two producers.
  always_comb begin
    ForwardA = SEL_RF;
    ForwardB = SEL_RF;
    if (mem_hits_rs)     ForwardA = SEL_MEM;
    else if (wb_hits_rs) ForwardA = SEL_WB;
    if (mem_hits_rt)     ForwardB = SEL_MEM;
    else if (wb_hits_rt) ForwardB = SEL_WB;
  end

  assign load_in_ex   = ex_mem_read && ex_reg_write && (ex_write_reg != REG_ZERO);
  assign load_hits_id = (ex_write_reg == ID_Rs) || (ID_UsesRt && (ex_write_reg == ID_Rt));
  // A flushed ID instruction never reaches EX, so it cannot need the load.
  assign Stall        = ID_Valid && !Flush && load_in_ex && load_hits_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_write_reg  <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_write_reg <= '0;
      mem_reg_write <= 1'b0;
      wb_write_reg  <= '0;
      wb_reg_write  <= 1'b0;
      StallCount    <= '0;
    end else begin
      mem_write_reg <= ex_write_reg;
      mem_reg_write <= ex_reg_write;
      wb_write_reg  <= mem_write_reg;
      wb_reg_write  <= mem_reg_write;
      if (Flush || Stall || !ID_Valid) begin
        ex_rs        <= '0;
        ex_rt        <= '0;
        ex_write_reg <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end else begin
        ex_rs        <= ID_Rs;
        ex_rt        <= ID_Rt;
        ex_write_reg <= ID_WriteReg;
        ex_reg_write <= ID_RegWrite;
        ex_mem_read  <= ID_MemRead;
      end
      if (Stall && (StallCount != {COUNT_WIDTH{1'b1}})) begin
        StallCount <= StallCount + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: directed pipeline scenarios followed by
// random instruction streams, compared against an instruction-level pipeline
// model. A second instance with a 4-bit counter exercises saturation.
module tb_forwarding_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ID_Valid = 1'b0;
  logic [4:0] ID_Rs = '0;
  logic [4:0] ID_Rt = '0;
  logic       ID_UsesRt = 1'b0;
  logic [4:0] ID_WriteReg = '0;
  logic       ID_RegWrite = 1'b0;
  logic       ID_MemRead = 1'b0;
  logic       Flush = 1'b0;

  logic [1:0]  fa, fb, fa4, fb4;
  logic        stall, stall4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  forwarding_hazard_unit u_dut (
    .clk(clk), .reset(reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRt(ID_UsesRt), .ID_WriteReg(ID_WriteReg), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .Flush(Flush),
    .ForwardA(fa), .ForwardB(fb), .Stall(stall), .StallCount(cnt)
  );

  forwarding_hazard_unit #(.REG_ADDR_BITS(5), .COUNT_WIDTH(4)) u_dut_sat (
    .clk(clk), .reset(reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRt(ID_UsesRt), .ID_WriteReg(ID_WriteReg), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .Flush(Flush),
    .ForwardA(fa4), .ForwardB(fb4), .Stall(stall4), .StallCount(cnt4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An instruction in flight; a bubble is the all-zero instruction.
  typedef struct packed {
    logic [4:0] rs, rt, wr;
    logic       rw, mr;
  } instr_t;

  instr_t pipe [3];   // index 0 = EX, 1 = MEM, 2 = WB (age in stages past ID)
  int     m_cnt16, m_cnt4;

  // Newest older instruction that writes register src supplies the value.
  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    for (int age = 1; age <= 2; age++) begin
      if (pipe[age].rw && pipe[age].wr != 0 && pipe[age].wr == src)
        return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic model_stall();
    instr_t ld;
    ld = pipe[0];
    if (!ID_Valid || Flush) return 1'b0;
    if (!(ld.mr && ld.rw) || ld.wr == 0) return 1'b0;
    return (ld.wr == ID_Rs) || (ID_UsesRt && ld.wr == ID_Rt);
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic [4:0] wr, input logic rw,
                       input logic mr, input logic fl, input logic rst);
    ID_Valid = v; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ur; ID_WriteReg = wr;
    ID_RegWrite = rw; ID_MemRead = mr; Flush = fl; reset = rst;
    #1;
  endtask

  // Compare against the model, then advance DUT and model across one edge.
  task automatic tick();
    logic   s;
    instr_t nw;
    s = model_stall();
    check("fwd_a", fa, model_fwd(pipe[0].rs));
    check("fwd_b", fb, model_fwd(pipe[0].rt));
    check("stall", stall, s);
    check("count16", cnt, m_cnt16);
    check("count4", cnt4, m_cnt4);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      if (s) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      nw = (Flush || s || !ID_Valid) ? instr_t'(0)
         : instr_t'({ID_Rs, ID_Rt, ID_WriteReg, ID_RegWrite, ID_MemRead});
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
    end
    @(negedge clk);
  endtask

  task automatic op(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                    input logic [4:0] wr, input logic rw, input logic mr);
    drive(1'b1, rs, rt, ur, wr, rw, mr, 1'b0, 1'b0);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int saved;

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_cnt16 = 0;
    m_cnt4  = 0;
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    check("rst_fa", fa, 2'b00);
    check("rst_stall", stall, 1'b0);
    check("rst_cnt", cnt, 0);

    // RAW distance 1: add $3 ; add $4,$3,$5
    op(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    op(5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    idle();
    check("d1_fa", fa, 2'b10);
    check("d1_fb", fb, 2'b00);
    check("d1_stall", stall, 1'b0);
    tick(); tick(); tick();

    // RAW distance 2
    op(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    op(5'd6, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    op(5'd3, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    idle();
    check("d2_fa", fa, 2'b01);
    // Two writers of $3 in MEM and WB: the younger one wins
    op(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    op(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    op(5'd3, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    idle();
    check("dbl_fa", fa, 2'b10);
    // $0 is never forwarded
    op(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    op(5'd0, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
    idle();
    check("r0_fa", fa, 2'b00);
    check("r0_fb", fb, 2'b00);
    tick(); tick(); tick();

    // Load-use: lw $8 ; add $9,$8,$8
    op(5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
    drive(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_stall", stall, 1'b1);
    check("lu_cnt0", cnt, 0);
    tick();
    check("lu_stall_once", stall, 1'b0);
    check("lu_cnt1", cnt, 1);
    tick();
    idle();
    check("lu_fa", fa, 2'b01);
    check("lu_fb", fb, 2'b01);
    check("lu_stall_after", stall, 1'b0);
    tick(); tick(); tick();

    // rt hazard only matters when rt is a source
    op(5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
    drive(1'b1, 5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rt_unused", stall, 1'b0);
    drive(1'b1, 5'd1, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rt_used", stall, 1'b1);
    tick(); tick(); idle(); tick(); tick(); tick();

    // Flush beats stall
    op(5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
    saved = int'(cnt);
    drive(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fl_stall", stall, 1'b0);
    tick();
    idle();
    check("fl_fa", fa, 2'b00);
    check("fl_fb", fb, 2'b00);
    check("fl_cnt", cnt, saved);
    tick(); tick();

    // Reset with a pending forward
    op(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    op(5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    idle();
    check("pre_rst_fa", fa, 2'b10);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    check("mid_rst_fa", fa, 2'b00);
    check("mid_rst_fb", fb, 2'b00);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_cnt", cnt, 0);

    // 20 load-use stalls: 4-bit counter saturates at 15
    for (int k = 0; k < 20; k++) begin
      op(5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
      op(5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
      op(5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    end
    idle();
    check("sat_cnt4", cnt4, 15);
    check("sat_cnt16", cnt, 20);

    // Random streams over a small register set to make hazards common
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            1'($urandom), 5'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) == 0);
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
